// File: rtl/banked_dpram.sv
// Banked true dual-port RAM with registered reads, cross-port write-mode control and a row-parallel clear engine.
// Define DPRAM_COLL_DETECT_EN to build the same-address collision flag; otherwise coll is tied low.
module banked_dpram #(
  parameter int               WIDTH   = 16,
  parameter int               DEPTH   = 512,
  parameter int               BANKS   = 4,
  parameter int               RD_LAT  = 2,
  parameter int               WR_MODE = 0,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     enb,
  input  logic                     wea,
  input  logic                     web,
  input  logic [$clog2(DEPTH)-1:0] addra,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  input  logic [WIDTH-1:0]         dina,
  input  logic [WIDTH-1:0]         dinb,
  output logic [WIDTH-1:0]         douta,
  output logic [WIDTH-1:0]         doutb,
  output logic                     valida,
  output logic                     validb,
  input  logic                     clr_start,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     coll
);

  localparam int AW   = $clog2(DEPTH);
  localparam int BW   = $clog2(BANKS);
  localparam int ROWS = DEPTH / BANKS;
  localparam int RW   = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t          state_q, state_n;
  logic [RW-1:0]   row_q, row_n;

  logic            acc_ok, clr_we;
  logic            a_wr, b_wr, a_rd, b_rd;
  logic            same_addr;
  logic [BW-1:0]   bank_a, bank_b;
  logic [RW-1:0]   row_a, row_b;
  logic [WIDTH-1:0] bank_ra [BANKS];
  logic [WIDTH-1:0] bank_rb [BANKS];
  logic [WIDTH-1:0] rd_word_a, rd_word_b;
  logic [WIDTH-1:0] q1a, q1b;
  logic            v1a, v1b;

  assign busy     = (state_q == CLEAR);
  assign clr_done = (state_q == DONE);

  assign acc_ok = !rst && !busy;
  assign clr_we = busy && !rst;
  assign a_wr   = acc_ok && ena && wea;
  assign b_wr   = acc_ok && enb && web;
  assign a_rd   = acc_ok && ena && !wea;
  assign b_rd   = acc_ok && enb && !web;

  assign same_addr = (addra == addrb);
  assign bank_a    = addra[BW-1:0];
  assign bank_b    = addrb[BW-1:0];
  assign row_a     = addra[AW-1:BW];
  assign row_b     = addrb[AW-1:BW];

  // Clear FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
    end
  end

  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_n = CLEAR;
          row_n   = '0;
        end
      end
      CLEAR: begin
        row_n = row_q + 1'b1;
        if (row_q == RW'(ROWS - 1)) begin
          state_n = DONE;
          row_n   = '0;
        end
      end
      DONE: begin
        row_n   = '0;
        state_n = clr_start ? CLEAR : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // One write process per bank; port A is written last so it wins a same-address tie.
  for (genvar g = 0; g < BANKS; g++) begin : g_bank
    localparam logic [BW-1:0] BID = BW'(g);
    logic [WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
      if (clr_we) begin
        mem[row_q] <= CLR_VAL;
      end else begin
        if (b_wr && (bank_b == BID)) mem[row_b] <= dinb;
        if (a_wr && (bank_a == BID)) mem[row_a] <= dina;
      end
    end

    assign bank_ra[g] = mem[row_a];
    assign bank_rb[g] = mem[row_b];
  end

  // Write-first forwards the other port's write data on an exact address match.
  always_comb begin
    rd_word_a = bank_ra[bank_a];
    rd_word_b = bank_rb[bank_b];
    if (WR_MODE == 1 && b_wr && same_addr) rd_word_a = dinb;
    if (WR_MODE == 1 && a_wr && same_addr) rd_word_b = dina;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1a    <= 1'b0;
      v1b    <= 1'b0;
      q1a    <= '0;
      q1b    <= '0;
      valida <= 1'b0;
      validb <= 1'b0;
      douta  <= '0;
      doutb  <= '0;
    end else if (RD_LAT == 1) begin
      valida <= a_rd;
      validb <= b_rd;
      if (a_rd) douta <= rd_word_a;
      if (b_rd) doutb <= rd_word_b;
    end else begin
      v1a    <= a_rd;
      v1b    <= b_rd;
      if (a_rd) q1a <= rd_word_a;
      if (b_rd) q1b <= rd_word_b;
      valida <= v1a;
      validb <= v1b;
      if (v1a) douta <= q1a;
      if (v1b) doutb <= q1b;
    end
  end

`ifdef DPRAM_COLL_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst) coll <= 1'b0;
    else     coll <= acc_ok && ena && enb && same_addr && (wea || web);
  end
`else
  assign coll = 1'b0;
`endif

endmodule

// File: tb/tb_banked_dpram.sv
// Bench for banked_dpram: two configurations (RD_LAT=2/read-first, RD_LAT=1/write-first) driven in lockstep
// and compared every cycle against an address-level memory model with a read-completion schedule.
module tb_banked_dpram;

  logic        clk, rst;
  logic        ena, enb, wea, web, clr_start;
  logic [8:0]  addra, addrb;
  logic [15:0] dina, dinb;

  logic [15:0] douta0, doutb0, douta1, doutb1;
  logic        valida0, validb0, valida1, validb1;
  logic        busy0, busy1, clr_done0, clr_done1, coll0, coll1;

  banked_dpram #(.WIDTH(16), .DEPTH(512), .BANKS(4), .RD_LAT(2), .WR_MODE(0), .CLR_VAL(16'hFFFF)) u0 (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta0), .doutb(doutb0), .valida(valida0), .validb(validb0),
    .clr_start(clr_start), .busy(busy0), .clr_done(clr_done0), .coll(coll0));

  banked_dpram #(.WIDTH(16), .DEPTH(512), .BANKS(4), .RD_LAT(1), .WR_MODE(1), .CLR_VAL(16'hFFFF)) u1 (
    .clk(clk), .rst(rst), .ena(ena), .enb(enb), .wea(wea), .web(web),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta1), .doutb(doutb1), .valida(valida1), .validb(validb1),
    .clr_start(clr_start), .busy(busy1), .clr_done(clr_done1), .coll(coll1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Model: flat word memory, clear progress, and per-output expected completions (0:u0 A, 1:u0 B, 2:u1 A, 3:u1 B).
  logic [15:0] mm [512];
  bit          ev [4][8];
  logic [15:0] ed [4][8];
  logic [15:0] last_d [4];
  bit          busy_m, done_m, coll_m;
  int          rows_m;
  string       names [4] = '{"u0_a", "u0_b", "u1_a", "u1_b"};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic sched(input int idx, input int lat, input logic [15:0] val);
    ev[idx][(cyc_n + lat) % 8] = 1'b1;
    ed[idx][(cyc_n + lat) % 8] = val;
  endtask

  task automatic model_step();
    bit          acc, coll_n, done_n;
    logic [15:0] old_a, old_b;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        last_d[i] = '0;
        for (int j = 0; j < 8; j++) ev[i][j] = 1'b0;
      end
      busy_m = 1'b0; done_m = 1'b0; coll_m = 1'b0; rows_m = 0;
    end else begin
      acc = !busy_m;
      if (acc && ena && !wea) begin
        old_a = mm[addra];
        sched(0, 2, old_a);
        sched(2, 1, (enb && web && addrb == addra) ? dinb : old_a);
      end
      if (acc && enb && !web) begin
        old_b = mm[addrb];
        sched(1, 2, old_b);
        sched(3, 1, (ena && wea && addra == addrb) ? dina : old_b);
      end
`ifdef DPRAM_COLL_DETECT_EN
      coll_n = acc && ena && enb && (addra == addrb) && (wea || web);
`else
      coll_n = 1'b0;
`endif
      if (acc && enb && web) mm[addrb] = dinb;
      if (acc && ena && wea) mm[addra] = dina;
      done_n = 1'b0;
      if (busy_m) begin
        for (int k = 0; k < 4; k++) mm[rows_m * 4 + k] = 16'hFFFF;
        rows_m++;
        if (rows_m == 128) begin
          busy_m = 1'b0;
          done_n = 1'b1;
        end
      end else if (clr_start) begin
        busy_m = 1'b1;
        rows_m = 0;
      end
      done_m = done_n;
      coll_m = coll_n;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] od [4];
    logic        ov [4];
    int          s;
    od = '{douta0, doutb0, douta1, doutb1};
    ov = '{valida0, validb0, valida1, validb1};
    s  = cyc_n % 8;
    for (int i = 0; i < 4; i++) begin
      if (ev[i][s]) begin
        chk({names[i], "_valid"}, 32'(ov[i]), 32'd1);
        chk({names[i], "_dout"}, 32'(od[i]), 32'(ed[i][s]));
        last_d[i] = ed[i][s];
        ev[i][s]  = 1'b0;
      end else begin
        chk({names[i], "_valid"}, 32'(ov[i]), 32'd0);
        chk({names[i], "_hold"}, 32'(od[i]), 32'(last_d[i]));
      end
    end
    chk("u0_busy", 32'(busy0), 32'(busy_m));
    chk("u1_busy", 32'(busy1), 32'(busy_m));
    chk("u0_clr_done", 32'(clr_done0), 32'(done_m));
    chk("u1_clr_done", 32'(clr_done1), 32'(done_m));
    chk("u0_coll", 32'(coll0), 32'(coll_m));
    chk("u1_coll", 32'(coll1), 32'(coll_m));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_in();
    ena = 1'b0; enb = 1'b0; wea = 1'b0; web = 1'b0; clr_start = 1'b0;
  endtask

  task automatic op(input bit ea, input bit wa, input int aa, input logic [15:0] da,
                    input bit eb, input bit wb, input int ab, input logic [15:0] db);
    ena = ea; wea = wa; addra = 9'(aa); dina = da;
    enb = eb; web = wb; addrb = 9'(ab); dinb = db;
    clr_start = 1'b0;
    cyc();
  endtask

  task automatic idles(input int n);
    idle_in();
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic sweep_read();
    for (int i = 0; i < 512; i++) op(1, 0, i, 16'h0, 1, 0, 511 - i, 16'h0);
    idles(3);
  endtask

  initial begin
    int busy_cnt, done_cnt;
    for (int i = 0; i < 512; i++) mm[i] = 'x;
    idle_in();
    addra = '0; addrb = '0; dina = '0; dinb = '0;
    rst = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    idles(2);

    // Full clear; random writes and a second clr_start while busy must be ignored.
    clr_start = 1'b1;
    cyc();
    busy_cnt = int'(busy0);
    done_cnt = int'(clr_done0);
    for (int i = 0; i < 132; i++) begin
      if (i < 128) begin
        ena = 1'b1; wea = 1'b1; addra = 9'($urandom_range(511)); dina = 16'($urandom);
        enb = 1'b1; web = 1'b1; addrb = 9'($urandom_range(511)); dinb = 16'($urandom);
        clr_start = (i == 60);
      end else begin
        idle_in();
      end
      cyc();
      busy_cnt += int'(busy0);
      done_cnt += int'(clr_done0);
    end
    chk("busy_cycles", 32'(busy_cnt), 32'd128);
    chk("clr_done_pulses", 32'(done_cnt), 32'd1);
    sweep_read();

    // Write then read next cycle on the other port.
    op(1, 1, 5, 16'h1234, 0, 0, 0, 16'h0);
    op(0, 0, 0, 16'h0, 1, 0, 5, 16'h0);
    idles(3);

    // Both ports write the same address: port A data must stick.
    op(1, 1, 16, 16'hAAAA, 1, 1, 16, 16'h5555);
    op(1, 0, 16, 16'h0, 1, 0, 16, 16'h0);
    idles(3);

    // Cross-port same-address write/read in both directions.
    op(1, 1, 32, 16'h0001, 0, 0, 0, 16'h0);
    op(1, 1, 32, 16'hBEEF, 1, 0, 32, 16'h0);
    op(0, 0, 0, 16'h0, 1, 1, 33, 16'h0002);
    op(1, 0, 33, 16'h0, 1, 1, 33, 16'hCAFE);
    op(1, 0, 32, 16'h0, 1, 0, 33, 16'h0);
    idles(3);

    // Random traffic concentrated on a small window to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      op(1'($urandom), 1'($urandom),
         ($urandom_range(3) == 0) ? int'($urandom_range(511)) : int'($urandom_range(15)), 16'($urandom),
         1'($urandom), 1'($urandom),
         ($urandom_range(3) == 0) ? int'($urandom_range(511)) : int'($urandom_range(15)), 16'($urandom));
    end
    idles(3);

    // Fill memory with random data, then abort a clear after 50 rows.
    for (int i = 0; i < 256; i++) op(1, 1, i, 16'($urandom), 1, 1, i + 256, 16'($urandom));
    idle_in();
    clr_start = 1'b1;
    cyc();
    idles(50);
    rst = 1'b1;
    op(1, 1, 300, 16'h1111, 1, 0, 301, 16'h0);
    rst = 1'b0;
    idles(2);

    // A read in flight across a reset is flushed.
    op(1, 0, 7, 16'h0, 1, 0, 400, 16'h0);
    rst = 1'b1;
    op(1, 0, 8, 16'h0, 1, 0, 9, 16'h0);
    rst = 1'b0;
    idles(3);
    sweep_read();

    // clr_start in the DONE cycle launches a fresh clear.
    for (int i = 0; i < 64; i++) op(1, 1, i * 8, 16'($urandom), 0, 0, 0, 16'h0);
    idle_in();
    clr_start = 1'b1;
    cyc();
    idles(128);
    clr_start = 1'b1;
    cyc();
    idles(131);
    sweep_read();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/banked_dpram.md
BANKED_DPRAM -- requirements
Module: banked_dpram

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 512, total words; SHALL be a power of two and a multiple of BANKS.
REQ-003 Parameter BANKS, default 4, power of two; word at address x lives in bank x mod BANKS, row x / BANKS.
REQ-004 Parameter RD_LAT, default 2, read latency in cycles; legal values 1 or 2.
REQ-005 Parameter WR_MODE, default 0; 0 = read-first, 1 = write-first, for cross-port same-address access.
REQ-006 Parameter CLR_VAL, default 0, WIDTH-bit value written by the clear engine.
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 ena, enb  in  1 each  port A/B access enable.
REQ-010 wea, web  in  1 each  1 = write, 0 = read.
REQ-011 addra, addrb  in  $clog2(DEPTH) each  word address.
REQ-012 dina, dinb  in  WIDTH each  write data.
REQ-013 douta, doutb  out  WIDTH each  registered read data.
REQ-014 valida, validb  out  1 each  one-cycle strobe: dout holds data of the read issued RD_LAT cycles earlier.
REQ-015 clr_start  in  1  pulse requesting a full-memory clear.
REQ-016 busy  out  1  clear engine active; port accesses ignored.
REQ-017 clr_done  out  1  one-cycle pulse at clear completion.
REQ-018 coll  out  1  collision flag (see Configuration).

Function
REQ-019 Read (en=1, we=0) accepted at cycle t SHALL present mem[addr] on dout with valid=1 at cycle t+RD_LAT.
REQ-020 dout SHALL hold its last value when no read completes; valid=0 in those cycles.
REQ-021 Write (en=1, we=1) at cycle t SHALL update mem[addr] at the cycle-t edge; no valid strobe produced.
REQ-022 Same address, A writes and B reads in the same cycle: WR_MODE=0 returns the old word, WR_MODE=1 returns dina; symmetric for B write / A read.
REQ-023 Both ports write the same address in the same cycle: dina SHALL be stored, dinb discarded.
REQ-024 Each bank SHALL have a single write-data mux; no dual always-block writes to one array.
REQ-025 Clear FSM states: IDLE, CLEAR, DONE.
REQ-026 IDLE -> CLEAR on clr_start=1; busy=1 from the next cycle.
REQ-027 CLEAR writes CLR_VAL to the same row of all BANKS each cycle, row counter 0..DEPTH/BANKS-1, i.e. DEPTH/BANKS cycles.
REQ-028 CLEAR -> DONE after the last row; DONE asserts clr_done=1, busy=0 for one cycle, then -> IDLE.
REQ-029 clr_start while busy=1 SHALL be ignored; clr_start in DONE SHALL start a new clear.
REQ-030 While busy=1, ena/enb SHALL be ignored: no write, no new valid; reads already in the pipeline still complete.

Reset
REQ-031 rst=1 SHALL set douta=doutb=0, valida=validb=0, coll=0, busy=0, clr_done=0, FSM=IDLE, row counter=0, and flush the read pipeline.
REQ-032 Memory contents SHALL NOT be altered by rst.
REQ-033 rst during CLEAR SHALL abort the clear: no clr_done pulse; already-cleared rows stay cleared.
REQ-034 Accesses in a cycle with rst=1 SHALL be ignored.

Configuration
REQ-035 Macro DPRAM_COLL_DETECT_EN: when defined, coll SHALL pulse 1 in cycle t+1 if at cycle t both ports are enabled, addra==addrb, and at least one port writes.
REQ-036 Without DPRAM_COLL_DETECT_EN, coll SHALL be tied 0 and no compare logic synthesised; all other behaviour is identical.

Verification (WIDTH=16, DEPTH=512, BANKS=4)
REQ-037 RD_LAT=2: write 0x1234 @ 0x005 via A, read 0x005 via B next cycle -> doutb=0x1234, validb=1 exactly 2 cycles after the read.
REQ-038 A writes 0xAAAA and B writes 0x5555 @ 0x010 same cycle, then read -> 0xAAAA; coll=1 one cycle later with macro, 0 without.
REQ-039 Pre-load 0x0001 @ 0x020; A writes 0xBEEF, B reads 0x020 same cycle -> doutb=0x0001 (WR_MODE=0) or 0xBEEF (WR_MODE=1).
REQ-040 clr_start with CLR_VAL=0xFFFF -> busy high 128 cycles, clr_done pulse once, every address reads 0xFFFF; writes during busy have no effect.
REQ-041 rst asserted 50 cycles into a clear -> busy=0, no clr_done, rows 0..49 read CLR_VAL, rows above keep old data.
REQ-042 Back-to-back reads on both ports every cycle, addresses 0..511 -> continuous valid, data in order, RD_LAT=1 and 2.
